// File: rtl/control_pkg.sv
// Shared cycle-state encoding for the control unit; signal_generator decodes
// the same {s2,s1,s0} values.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'b000,
        ST_DECODE   = 3'b001,
        ST_ALU_CTRL = 3'b011,
        ST_READ     = 3'b010,
        ST_END      = 3'b100
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle on which the
// outstanding access has waited MEM_TIMEOUT cycles (0 disables the timeout).
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic clear,
    output logic timeout
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) + 1 : 1;

    logic [CW-1:0] count_r;

    // wait counter: restarts whenever the sequencer changes state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (active) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);
            assign timeout = active & (count_r == LIMIT);
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/control_sequencer.sv
// Cycle-state FSM of the control unit: FETCH/DECODE/ALU_CTRL/READ/END with
// memory stalls, halt/start, single-step, retire counting and bus timeout.
module control_sequencer
    import control_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_instr,
    input  logic             ld,
    input  logic             st,
    input  logic             push,
    input  logic             pop,
    input  logic             mem_ready,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic             halted,
    output logic             mem_req,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired_count
);

    state_e           state_r, state_next_s;
    logic             halted_r, halted_next_s;
    logic             bus_error_r, bus_error_next_s;
    logic             step_pending_r, step_pending_next_s;
    logic [CNT_W-1:0] retired_r, retired_next_s;
    logic             mem_req_s, leave_fetch_s;
    logic             wait_active_s, wait_clear_s, timeout_s;

    // memory request: fetch unless waiting for a step, plus data phases by class
    always_comb begin
        mem_req_s = 1'b0;
        if (halted_r) begin
            mem_req_s = 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: mem_req_s = ~(step_mode & ~step_pending_r);
                ST_READ:  mem_req_s = ld | pop;
                ST_END:   mem_req_s = st | push;
                default:  mem_req_s = 1'b0;
            endcase
        end
    end

    assign wait_active_s = mem_req_s & ~mem_ready;
    assign wait_clear_s  = halted_r | (state_next_s != state_r);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .active  (wait_active_s),
        .clear   (wait_clear_s),
        .timeout (timeout_s)
    );

    // next-state, halt/error flags, step authorisation and retire count
    always_comb begin
        state_next_s        = state_r;
        halted_next_s       = halted_r;
        bus_error_next_s    = bus_error_r;
        retired_next_s      = retired_r;
        leave_fetch_s       = 1'b0;

        if (halted_r) begin
            state_next_s = ST_FETCH;
            if (start) begin
                halted_next_s    = 1'b0;
                bus_error_next_s = 1'b0;
            end else begin
                halted_next_s    = 1'b1;
            end
        end else if (timeout_s) begin
            state_next_s     = ST_FETCH;
            halted_next_s    = 1'b1;
            bus_error_next_s = 1'b1;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem_req_s && mem_ready) begin
                        state_next_s  = ST_DECODE;
                        leave_fetch_s = 1'b1;
                    end else begin
                        state_next_s  = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (halt_instr) begin
                        state_next_s  = ST_FETCH;
                        halted_next_s = 1'b1;
                    end else begin
                        state_next_s  = ST_ALU_CTRL;
                    end
                end
                ST_ALU_CTRL: state_next_s = ST_READ;
                ST_READ: begin
                    if (!mem_req_s || mem_ready) begin
                        state_next_s = ST_END;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end
                ST_END: begin
                    if (!mem_req_s || mem_ready) begin
                        state_next_s   = ST_FETCH;
                        retired_next_s = retired_r + CNT_W'(1);
                    end else begin
                        state_next_s   = ST_END;
                    end
                end
                default: state_next_s = ST_FETCH;
            endcase
        end

        // a step arriving as FETCH consumes the pending one authorises another
        if (step_mode && step) begin
            step_pending_next_s = 1'b1;
        end else if (leave_fetch_s) begin
            step_pending_next_s = 1'b0;
        end else begin
            step_pending_next_s = step_pending_r;
        end
    end

    // state and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= ST_FETCH;
            halted_r       <= 1'b1;
            bus_error_r    <= 1'b0;
            step_pending_r <= 1'b0;
            retired_r      <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_next_s;
            halted_r       <= halted_next_s;
            bus_error_r    <= bus_error_next_s;
            step_pending_r <= step_pending_next_s;
            retired_r      <= retired_next_s;
        end
    end

    assign {s2, s1, s0}  = state_r;
    assign halted        = halted_r;
    assign bus_error     = bus_error_r;
    assign retired_count = retired_r;
    assign mem_req       = mem_req_s;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_control_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, step_mode, step, halt_instr;
    logic ld, st, push, pop, mem_ready;
    logic s2, s1, s0, halted, mem_req, bus_error;
    logic [CNT_W-1:0] retired_count;

    control_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .step_mode(step_mode),
        .step(step), .halt_instr(halt_instr), .ld(ld), .st(st), .push(push),
        .pop(pop), .mem_ready(mem_ready), .s2(s2), .s1(s1), .s0(s0),
        .halted(halted), .mem_req(mem_req), .bus_error(bus_error),
        .retired_count(retired_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: phase index 0..4 walks the instruction (fetch, decode, alu, read, end)
    int phase_code[5] = '{0, 1, 3, 2, 4};
    int m_ph, m_ret, m_wait;
    bit m_halted, m_berr, m_pend;

    function automatic bit model_req();
        if (m_halted) return 1'b0;
        if (m_ph == 0) return !(step_mode && !m_pend);
        if (m_ph == 3) return ld || pop;
        if (m_ph == 4) return st || push;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state", 32'({s2, s1, s0}), 32'(phase_code[m_ph]));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("mem_req", 32'(mem_req), 32'(model_req()));
        chk("bus_error", 32'(bus_error), 32'(m_berr));
        chk("retired", 32'(retired_count), 32'(m_ret));
    endtask

    task automatic model_step();
        bit req, tmo, left;
        req  = model_req();
        left = 1'b0;
        if (!reset_n) begin
            m_ph = 0; m_halted = 1'b1; m_berr = 1'b0; m_ret = 0; m_pend = 1'b0; m_wait = 0;
            return;
        end
        tmo = (MEM_TIMEOUT > 0) && req && !mem_ready && (m_wait == MEM_TIMEOUT - 1);
        if (m_halted) begin
            m_ph = 0; m_wait = 0;
            if (start) begin m_halted = 1'b0; m_berr = 1'b0; end
        end else if (tmo) begin
            m_halted = 1'b1; m_berr = 1'b1; m_ph = 0; m_wait = 0;
        end else if (m_ph == 0 && !req) begin
            m_wait = m_wait;
        end else if (!req || mem_ready) begin
            m_wait = 0;
            case (m_ph)
                0: begin m_ph = 1; left = 1'b1; end
                1: if (halt_instr) begin m_halted = 1'b1; m_ph = 0; end else m_ph = 2;
                2: m_ph = 3;
                3: m_ph = 4;
                default: begin m_ph = 0; m_ret = (m_ret + 1) % (1 << CNT_W); end
            endcase
        end else begin
            m_wait++;
        end
        if (step_mode && step) m_pend = 1'b1;
        else if (left) m_pend = 1'b0;
    endtask

    // one clock: check outputs for the inputs now applied, advance model, step clock
    task automatic tick();
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_alu_instr();
        repeat (5) tick();
    endtask

    int exp_seq[6] = '{0, 1, 3, 2, 4, 0};
    int stuck;

    initial begin
        reset_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_instr = 1'b0;
        ld = 1'b0; st = 1'b0; push = 1'b0; pop = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_ph = 0; m_halted = 1'b1; m_berr = 1'b0; m_ret = 0; m_pend = 1'b0; m_wait = 0;
        chk("rst_state", 32'({s2, s1, s0}), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_retired", 32'(retired_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // start, zero-wait ALU instruction
        start = 1'b1; tick(); start = 1'b0;
        mem_ready = 1'b1;
        chk("fetch_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("alu_seq", 32'({s2, s1, s0}), 32'(exp_seq[i]));
            if (i < 5) tick();
        end
        chk("alu_retired", 32'(retired_count), 32'd1);

        // load with three wait cycles in READ
        ld = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ld_read_hold", 32'({s2, s1, s0}), 32'd2);
            chk("ld_read_req", 32'(mem_req), 32'd1);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        chk("ld_end", 32'({s2, s1, s0}), 32'd4);
        tick();
        ld = 1'b0;
        chk("ld_retired", 32'(retired_count), 32'd2);

        // halt in DECODE, restart
        tick();
        halt_instr = 1'b1; tick(); halt_instr = 1'b0;
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_state", 32'({s2, s1, s0}), 32'd0);
        chk("halt_retired", 32'(retired_count), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_req", 32'(mem_req), 32'd1);

        // fetch timeout, then ready on the last allowed cycle
        mem_ready = 1'b0;
        repeat (14) tick();
        chk("tmo_not_yet", 32'(bus_error), 32'd0);
        tick();
        chk("tmo_error", 32'(bus_error), 32'd1);
        chk("tmo_halted", 32'(halted), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        chk("tmo_cleared", 32'(bus_error), 32'd0);
        repeat (14) tick();
        mem_ready = 1'b1; tick();
        chk("ready_wins", 32'(bus_error), 32'd0);
        chk("ready_wins_st", 32'({s2, s1, s0}), 32'd1);
        repeat (4) tick();
        chk("tmo_retired", 32'(retired_count), 32'd3);

        // single-step: two pulses, two instructions
        step_mode = 1'b1;
        repeat (3) tick();
        chk("step_hold", 32'(mem_req), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step = 1'b1; tick(); step = 1'b0;
            run_alu_instr();
        end
        tick();
        chk("step_retired", 32'(retired_count), 32'd5);
        chk("step_idle_req", 32'(mem_req), 32'd0);
        step_mode = 1'b0;

        // reset mid-wait in READ
        pop = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1; pop = 1'b0;
        chk("midrst_state", 32'({s2, s1, s0}), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd1);
        chk("midrst_retired", 32'(retired_count), 32'd0);

        // counter wrap
        start = 1'b1; tick(); start = 1'b0;
        mem_ready = 1'b1;
        repeat (15) run_alu_instr();
        chk("wrap_max", 32'(retired_count), 32'd15);
        run_alu_instr();
        chk("wrap_zero", 32'(retired_count), 32'd0);

        // randomized traffic
        stuck = 0;
        for (int c = 0; c < 3000; c++) begin
            if (stuck == 0 && $urandom_range(0, 199) == 0) stuck = 20;
            if (stuck > 0) begin mem_ready = 1'b0; stuck--; end
            else mem_ready = ($urandom_range(0, 3) != 0);
            start      = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) step_mode = ~step_mode;
            step       = ($urandom_range(0, 5) == 0);
            halt_instr = ($urandom_range(0, 24) == 0);
            reset_n    = ($urandom_range(0, 499) != 0);
            if (m_ph == 0) begin
                ld   = ($urandom_range(0, 2) == 0);
                st   = ($urandom_range(0, 2) == 0);
                push = ($urandom_range(0, 2) == 0);
                pop  = ($urandom_range(0, 2) == 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
